// File: rtl/ksa4_share_ctrl.sv
// ----------------------------------------------------------------------------
// ksa4_share_ctrl: round-robin issue controller sharing one pipelined 4-bit adder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ksa4_share_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic       GCLK_Pad,
  input  logic       rst_Pad,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0_op,
  input  logic [3:0] a1_op,
  input  logic [3:0] b0_op,
  input  logic [3:0] b1_op,
  input  logic       cin0,
  input  logic       cin1,
  input  logic       flush,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  output logic       add_valid,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [3:0] rsp_sum,
  output logic       rsp_cout,
  output logic       idle,
  output logic [7:0] ops_count
);

  logic               r_gnt0, r_gnt1, r_last_gnt;
  logic               r_add_valid, r_add_cin;
  logic [3:0]         r_add_a, r_add_b;
  logic               r_rsp0, r_rsp1, r_rsp_cout, r_idle;
  logic [3:0]         r_rsp_sum;
  logic [7:0]         r_ops_count;
  logic [LATENCY-1:0] r_tag_v, r_tag_id;

  logic w_elig0, w_elig1, w_grant0, w_grant1, w_issue;

  // Masking on the registered grant gives a requester one cycle to drop or renew req.
  always_comb begin
    w_elig0  = req0 & ~r_gnt0 & ~flush;
    w_elig1  = req1 & ~r_gnt1 & ~flush;
    w_grant0 = w_elig0 & (~w_elig1 | r_last_gnt);
    w_grant1 = w_elig1 & ~w_grant0;
    w_issue  = w_grant0 | w_grant1;
  end

  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_add_valid <= 1'b0;
      r_add_a     <= 4'd0;
      r_add_b     <= 4'd0;
      r_add_cin   <= 1'b0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_rsp0      <= 1'b0;
      r_rsp1      <= 1'b0;
      r_rsp_sum   <= 4'd0;
      r_rsp_cout  <= 1'b0;
      r_ops_count <= 8'd0;
      r_idle      <= 1'b1;
    end else begin
      r_gnt0      <= w_grant0;
      r_gnt1      <= w_grant1;
      r_add_valid <= w_issue;
      r_add_a     <= w_grant0 ? a0_op : (w_grant1 ? a1_op : 4'd0);
      r_add_b     <= w_grant0 ? b0_op : (w_grant1 ? b1_op : 4'd0);
      r_add_cin   <= w_grant0 ? cin0  : (w_grant1 & cin1);
      if (w_issue) begin
        r_last_gnt <= w_grant1;
      end

      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_grant1;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end

      r_rsp0 <= r_tag_v[LATENCY-1] & ~r_tag_id[LATENCY-1];
      r_rsp1 <= r_tag_v[LATENCY-1] &  r_tag_id[LATENCY-1];
      if (r_tag_v[LATENCY-1]) begin
        r_rsp_sum   <= add_sum;
        r_rsp_cout  <= add_cout;
        r_ops_count <= r_ops_count + 8'd1;
      end

      // Registered view of the drain state, so idle rises the cycle after the final response.
      r_idle <= ~r_gnt0 & ~r_gnt1 & ~(|r_tag_v);
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_cin    = r_add_cin;
  assign add_valid  = r_add_valid;
  assign rsp0_valid = r_rsp0;
  assign rsp1_valid = r_rsp1;
  assign rsp_sum    = r_rsp_sum;
  assign rsp_cout   = r_rsp_cout;
  assign idle       = r_idle;
  assign ops_count  = r_ops_count;

endmodule

`default_nettype wire

// File: tb/tb_ksa4_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ksa4_share_ctrl: directed bench for ksa4_share_ctrl with a pipelined adder model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ksa4_share_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst, req0, req1, cin0, cin1, flush;
  logic [3:0] a0_op, a1_op, b0_op, b1_op;
  logic       gnt0, gnt1, add_cin, add_valid, add_cout;
  logic [3:0] add_a, add_b, add_sum;
  logic       rsp0_valid, rsp1_valid, rsp_cout, idle;
  logic [3:0] rsp_sum;
  logic [7:0] ops_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ksa4_share_ctrl #(.LATENCY(LAT)) dut (
    .GCLK_Pad(clk), .rst_Pad(rst), .req0(req0), .req1(req1),
    .a0_op(a0_op), .a1_op(a1_op), .b0_op(b0_op), .b1_op(b1_op),
    .cin0(cin0), .cin1(cin1), .flush(flush),
    .gnt0(gnt0), .gnt1(gnt1), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_valid(add_valid),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .idle(idle), .ops_count(ops_count)
  );

  // Adder model: result of the operands launched at edge k is present before edge k+LAT.
  logic [4:0] apipe [LAT-1];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    for (int j = 1; j < LAT - 1; j++) apipe[j] <= apipe[j-1];
  end
  assign {add_cout, add_sum} = apipe[LAT-2];

  logic [27:0] obs;
  assign obs = {gnt0, gnt1, add_valid, add_a, add_b, add_cin,
                rsp0_valid, rsp1_valid, rsp_sum, rsp_cout, idle, ops_count};

  function automatic logic [27:0] ob(input logic g0, input logic g1, input logic v,
                                     input logic [3:0] a, input logic [3:0] b, input logic c,
                                     input logic r0, input logic r1, input logic [3:0] s,
                                     input logic co, input logic idl, input logic [7:0] cnt);
    return {g0, g1, v, a, b, c, r0, r1, s, co, idl, cnt};
  endfunction

  typedef struct packed {
    logic [1:0]  req;
    logic [27:0] exp;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nrsp, ngnt;
    logic exp_g;

    tbl[0]  = {2'b11, ob(1,0,1,4'h7,4'h6,1, 0,0,4'h0,0, 1,8'd0)};
    tbl[1]  = {2'b11, ob(0,1,1,4'h3,4'h5,1, 0,0,4'h0,0, 0,8'd0)};
    tbl[2]  = {2'b11, ob(1,0,1,4'h7,4'h6,1, 0,0,4'h0,0, 0,8'd0)};
    tbl[3]  = {2'b11, ob(0,1,1,4'h3,4'h5,1, 0,0,4'h0,0, 0,8'd0)};
    tbl[4]  = {2'b11, ob(1,0,1,4'h7,4'h6,1, 1,0,4'hE,0, 0,8'd1)};
    tbl[5]  = {2'b11, ob(0,1,1,4'h3,4'h5,1, 0,1,4'h9,0, 0,8'd2)};
    tbl[6]  = {2'b11, ob(1,0,1,4'h7,4'h6,1, 1,0,4'hE,0, 0,8'd3)};
    tbl[7]  = {2'b11, ob(0,1,1,4'h3,4'h5,1, 0,1,4'h9,0, 0,8'd4)};
    tbl[8]  = {2'b00, ob(0,0,0,4'h0,4'h0,0, 1,0,4'hE,0, 0,8'd5)};
    tbl[9]  = {2'b00, ob(0,0,0,4'h0,4'h0,0, 0,1,4'h9,0, 0,8'd6)};
    tbl[10] = {2'b00, ob(0,0,0,4'h0,4'h0,0, 1,0,4'hE,0, 0,8'd7)};
    tbl[11] = {2'b00, ob(0,0,0,4'h0,4'h0,0, 0,1,4'h9,0, 0,8'd8)};
    tbl[12] = {2'b00, ob(0,0,0,4'h0,4'h0,0, 0,0,4'h9,0, 1,8'd8)};

    a0_op = 4'h0; b0_op = 4'h0; cin0 = 1'b0;
    a1_op = 4'h0; b1_op = 4'h0; cin1 = 1'b0;

    // Reset state, then a single op on port 0
    do_reset();
    chk("reset_state", obs, ob(0,0,0,0,0,0,0,0,0,0,1,0));
    a0_op = 4'hC; b0_op = 4'h4; cin0 = 1'b0; req0 = 1'b1;
    step();
    chk("single_issue", obs, ob(1,0,1,4'hC,4'h4,0,0,0,0,0,1,0));
    req0 = 1'b0;
    for (int e = 2; e <= LAT; e++) begin
      step();
      chk("single_wait", obs, ob(0,0,0,0,0,0,0,0,0,0,0,0));
    end
    step();
    chk("single_rsp", obs, ob(0,0,0,0,0,0,1,0,4'h0,1,0,8'd1));

    // Tie break and alternating responses
    do_reset();
    a0_op = 4'h7; b0_op = 4'h6; cin0 = 1'b1;
    a1_op = 4'h3; b1_op = 4'h5; cin1 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      {req0, req1} = tbl[i].req;
      step();
      chk($sformatf("tie_row%0d", i), obs, tbl[i].exp);
    end

    // Single-requester throughput
    do_reset();
    a1_op = 4'hA; b1_op = 4'h9; cin1 = 1'b0;
    nrsp = 0; ngnt = 0;
    for (int e = 1; e <= 16; e++) begin
      req1 = (e <= 10);
      step();
      exp_g = (e <= 10) && (e % 2 == 1);
      chk("thr_gnt", {gnt0, gnt1}, {1'b0, exp_g});
      chk("thr_pads", {add_valid, add_a, add_b, add_cin},
          exp_g ? {1'b1, 4'hA, 4'h9, 1'b0} : 10'd0);
      if (gnt1) ngnt++;
      if (rsp1_valid) begin
        nrsp++;
        chk("thr_rsp_val", {rsp_cout, rsp_sum}, 5'h13);
      end
      if (rsp0_valid) chk("thr_rsp0", rsp0_valid, 1'b0);
    end
    chk("thr_grants", ngnt, 5);
    chk("thr_rsps", nrsp, 5);

    // Flush with operations in flight
    do_reset();
    a0_op = 4'h7; b0_op = 4'h6; cin0 = 1'b1;
    a1_op = 4'h3; b1_op = 4'h5; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1; nrsp = 0;
    for (int e = 1; e <= 12; e++) begin
      flush = (e >= 4);
      step();
      chk("flush_gnt", {gnt0, gnt1}, {e == 1 || e == 3, e == 2});
      if (rsp0_valid || rsp1_valid) nrsp++;
      if (e == 7) chk("flush_idle_lo", idle, 1'b0);
      if (e == 8) chk("flush_idle_hi", idle, 1'b1);
    end
    chk("flush_rsps", nrsp, 3);
    chk("flush_count", ops_count, 8'd3);
    flush = 1'b0; req0 = 1'b0; req1 = 1'b0;

    // Reset two cycles after an issue
    do_reset();
    a0_op = 4'hC; b0_op = 4'h4; cin0 = 1'b0; req0 = 1'b1;
    step();
    chk("mid_issue", gnt0, 1'b1);
    req0 = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_reset_state", obs, ob(0,0,0,0,0,0,0,0,0,0,1,0));
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      chk("mid_no_rsp", {rsp0_valid, rsp1_valid, ops_count}, 10'd0);
    end
    chk("mid_idle", idle, 1'b1);

    // Counter wrap over 256 operations
    do_reset();
    a0_op = 4'h7; b0_op = 4'h6; cin0 = 1'b1;
    a1_op = 4'h3; b1_op = 4'h5; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1; nrsp = 0;
    for (int e = 1; e <= 400 && nrsp < 256; e++) begin
      if (e == 257) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step();
      if (rsp0_valid || rsp1_valid) begin
        nrsp++;
        if (nrsp == 255) chk("wrap_255", ops_count, 8'd255);
        if (nrsp == 256) chk("wrap_0", ops_count, 8'd0);
      end
    end
    chk("wrap_rsps", nrsp, 256);
    req0 = 1'b0; req1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
